// File: rtl/wb_memory_router_if.sv
// Wishbone-style point-to-point bus bundle used for the master port and
// every slave port of the memory router. The master drives the request
// fields; the slave returns read data and acknowledge.
interface wb_memory_router_if #(
  parameter int unsigned BYTE_AMNT = 4
);

  localparam int unsigned DW = 8 * BYTE_AMNT;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [BYTE_AMNT-1:0] sel;
  logic [31:0]          adr;
  logic [DW-1:0]        dat_w;
  logic [DW-1:0]        dat_r;
  logic                 ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );

endinterface : wb_memory_router_if

// File: rtl/wb_memory_router.sv
// Single-master address decoder/router. Steers the core's bus cycle to
// exactly one of ROM, RAM, CSR memory (MTIME/MTIMECMP/MSIP) or UART 0 and
// returns that slave's data and acknowledge combinationally. Accesses to
// unmapped addresses and writes to ROM are terminated by a one-cycle error
// acknowledge with zero read data, so the core never stalls forever.
module wb_memory_router #(
  parameter int unsigned BYTE_AMNT     = 4,
  parameter logic [31:0] ROM_ADDR_INIT = 32'h0000_0000,
  parameter logic [31:0] ROM_ADDR_END  = 32'h00FF_FFFF,
  parameter logic [31:0] RAM_ADDR_INIT = 32'h0100_0000,
  parameter logic [31:0] RAM_ADDR_END  = 32'h04FF_FFFF,
  parameter logic [63:0] MTIME_ADDR    = 64'h0000_0000_3FFF_E000,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_3FFF_F000,
  parameter logic [63:0] MSIP_ADDR     = 64'h0000_0000_4000_0000,
  parameter logic [31:0] UART_0_ADDR   = 32'h1001_3000
) (
  input logic                CLK_I,
  input logic                RST_I,
  wb_memory_router_if.slave  cpu,
  wb_memory_router_if.master rom,
  wb_memory_router_if.master ram,
  wb_memory_router_if.master csr_mem,
  wb_memory_router_if.master uart_0
);

  localparam int unsigned DW = 8 * BYTE_AMNT;

  // Inclusive window sizes minus one; a window match is
  // (addr - base) <= span, so addresses below the base wrap high and miss.
  localparam logic [31:0] ROM_SPAN      = ROM_ADDR_END - ROM_ADDR_INIT;
  localparam logic [31:0] RAM_SPAN      = RAM_ADDR_END - RAM_ADDR_INIT;
  localparam logic [31:0] UART_0_SPAN   = 32'd31;
  localparam logic [63:0] MTIME_SPAN    = 64'd7;
  localparam logic [63:0] MTIMECMP_SPAN = 64'd7;
  localparam logic [63:0] MSIP_SPAN     = 64'd3;

  typedef enum logic [2:0] {
    TGT_ERR  = 3'd0,
    TGT_ROM  = 3'd1,
    TGT_RAM  = 3'd2,
    TGT_CSR  = 3'd3,
    TGT_UART = 3'd4
  } target_e;

  logic [63:0]   adr64_s;
  logic          rom_hit_s;
  logic          ram_hit_s;
  logic          csr_hit_s;
  logic          uart_hit_s;
  target_e       target_s;
  logic [DW-1:0] slave_dat_s;
  logic          slave_ack_s;
  logic          err_hit_s;
  logic          err_ack_d;
  logic          err_ack_q;

  // Address window matching; CSR compares run on the zero-extended address.
  always_comb begin
    adr64_s    = {32'h0000_0000, cpu.adr};
    rom_hit_s  = ((cpu.adr - ROM_ADDR_INIT) <= ROM_SPAN);
    ram_hit_s  = ((cpu.adr - RAM_ADDR_INIT) <= RAM_SPAN);
    uart_hit_s = ((cpu.adr - UART_0_ADDR) <= UART_0_SPAN);
    csr_hit_s  = ((adr64_s - MTIME_ADDR) <= MTIME_SPAN)
              || ((adr64_s - MTIMECMP_ADDR) <= MTIMECMP_SPAN)
              || ((adr64_s - MSIP_ADDR) <= MSIP_SPAN);
  end

  // Priority resolution (CSR > UART > RAM > ROM); ROM writes fall to the error responder.
  always_comb begin
    target_s = TGT_ERR;
    if (csr_hit_s) begin
      target_s = TGT_CSR;
    end else if (uart_hit_s) begin
      target_s = TGT_UART;
    end else if (ram_hit_s) begin
      target_s = TGT_RAM;
    end else if (rom_hit_s && !cpu.we) begin
      target_s = TGT_ROM;
    end else begin
      target_s = TGT_ERR;
    end
  end

  // Steer cycle/strobe/write-enable to the selected slave and pick its response.
  always_comb begin
    rom.cyc     = 1'b0;
    rom.stb     = 1'b0;
    rom.we      = 1'b0;
    ram.cyc     = 1'b0;
    ram.stb     = 1'b0;
    ram.we      = 1'b0;
    csr_mem.cyc = 1'b0;
    csr_mem.stb = 1'b0;
    csr_mem.we  = 1'b0;
    uart_0.cyc  = 1'b0;
    uart_0.stb  = 1'b0;
    uart_0.we   = 1'b0;
    slave_dat_s = '0;
    slave_ack_s = 1'b0;
    case (target_s)
      TGT_ROM: begin
        rom.cyc     = cpu.cyc;
        rom.stb     = cpu.stb;
        slave_dat_s = rom.dat_r;
        slave_ack_s = rom.ack;
      end
      TGT_RAM: begin
        ram.cyc     = cpu.cyc;
        ram.stb     = cpu.stb;
        ram.we      = cpu.we;
        slave_dat_s = ram.dat_r;
        slave_ack_s = ram.ack;
      end
      TGT_CSR: begin
        csr_mem.cyc = cpu.cyc;
        csr_mem.stb = cpu.stb;
        csr_mem.we  = cpu.we;
        slave_dat_s = csr_mem.dat_r;
        slave_ack_s = csr_mem.ack;
      end
      TGT_UART: begin
        uart_0.cyc  = cpu.cyc;
        uart_0.stb  = cpu.stb;
        uart_0.we   = cpu.we;
        slave_dat_s = uart_0.dat_r;
        slave_ack_s = uart_0.ack;
      end
      default: begin
        slave_dat_s = '0;
        slave_ack_s = 1'b0;
      end
    endcase
  end

  // Address, write data and byte selects are passed unmodified to every slave;
  // slaves without byte lanes simply ignore sel.
  assign rom.adr       = cpu.adr;
  assign rom.dat_w     = cpu.dat_w;
  assign rom.sel       = cpu.sel;
  assign ram.adr       = cpu.adr;
  assign ram.dat_w     = cpu.dat_w;
  assign ram.sel       = cpu.sel;
  assign csr_mem.adr   = cpu.adr;
  assign csr_mem.dat_w = cpu.dat_w;
  assign csr_mem.sel   = cpu.sel;
  assign uart_0.adr    = cpu.adr;
  assign uart_0.dat_w  = cpu.dat_w;
  assign uart_0.sel    = cpu.sel;

  // Error responder next state: pulse once per strobed error access, never two cycles in a row.
  always_comb begin
    err_hit_s = cpu.cyc && cpu.stb && (target_s == TGT_ERR);
    if (err_ack_q) begin
      err_ack_d = 1'b0;
    end else begin
      err_ack_d = err_hit_s;
    end
  end

  // Error acknowledge register; reset drops any pending pulse immediately.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      err_ack_q <= 1'b0;
    end else begin
      err_ack_q <= err_ack_d;
    end
  end

  // Response to the master: zero data during an error ACK, no ACK outside a cycle.
  always_comb begin
    cpu.dat_r = slave_dat_s;
    cpu.ack   = 1'b0;
    if (err_ack_q) begin
      cpu.dat_r = '0;
    end else begin
      cpu.dat_r = slave_dat_s;
    end
    if (cpu.cyc) begin
      cpu.ack = slave_ack_s | err_ack_q;
    end else begin
      cpu.ack = 1'b0;
    end
  end

endmodule : wb_memory_router

// File: tb/tb_wb_memory_router.sv
// Self-checking bench for wb_memory_router: directed test-plan accesses plus
// randomized addresses, checked against a window-table reference model.
module tb_wb_memory_router;

  localparam int T_ERR  = 0;
  localparam int T_ROM  = 1;
  localparam int T_RAM  = 2;
  localparam int T_CSR  = 3;
  localparam int T_UART = 4;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sdat [0:4];

  wb_memory_router_if #(.BYTE_AMNT(4)) cpu_bus ();
  wb_memory_router_if #(.BYTE_AMNT(4)) rom_bus ();
  wb_memory_router_if #(.BYTE_AMNT(4)) ram_bus ();
  wb_memory_router_if #(.BYTE_AMNT(4)) csr_bus ();
  wb_memory_router_if #(.BYTE_AMNT(4)) uart_bus ();

  wb_memory_router dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .cpu     (cpu_bus),
    .rom     (rom_bus),
    .ram     (ram_bus),
    .csr_mem (csr_bus),
    .uart_0  (uart_bus)
  );

  always #5 CLK_I = ~CLK_I;

  // Memory map as a priority-ordered table of inclusive windows.
  function automatic int ref_target(input logic [31:0] a, input logic we);
    logic [31:0] lo [0:6];
    logic [31:0] hi [0:6];
    int          id [0:6];
    int          res;
    bit          found;
    lo[0] = 32'h3FFF_E000; hi[0] = 32'h3FFF_E007; id[0] = T_CSR;
    lo[1] = 32'h3FFF_F000; hi[1] = 32'h3FFF_F007; id[1] = T_CSR;
    lo[2] = 32'h4000_0000; hi[2] = 32'h4000_0003; id[2] = T_CSR;
    lo[3] = 32'h1001_3000; hi[3] = 32'h1001_301F; id[3] = T_UART;
    lo[4] = 32'h0100_0000; hi[4] = 32'h04FF_FFFF; id[4] = T_RAM;
    lo[5] = 32'h0000_0000; hi[5] = 32'h00FF_FFFF; id[5] = T_ROM;
    lo[6] = 32'hFFFF_FFFF; hi[6] = 32'h0000_0000; id[6] = T_ERR;
    res   = T_ERR;
    found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!found && a >= lo[i] && a <= hi[i]) begin
        found = 1'b1;
        res   = (id[i] == T_ROM && we) ? T_ERR : id[i];
      end
    end
    return res;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Selected slave gets sel_ack; all others get random ACKs that must never leak.
  task automatic drive_slaves(input int tgt, input logic sel_ack);
    rom_bus.dat_r  = sdat[T_ROM];
    ram_bus.dat_r  = sdat[T_RAM];
    csr_bus.dat_r  = sdat[T_CSR];
    uart_bus.dat_r = sdat[T_UART];
    rom_bus.ack  = (tgt == T_ROM)  ? sel_ack : ($urandom_range(0, 1) == 1);
    ram_bus.ack  = (tgt == T_RAM)  ? sel_ack : ($urandom_range(0, 1) == 1);
    csr_bus.ack  = (tgt == T_CSR)  ? sel_ack : ($urandom_range(0, 1) == 1);
    uart_bus.ack = (tgt == T_UART) ? sel_ack : ($urandom_range(0, 1) == 1);
  endtask

  task automatic chk_route(input int tgt, input logic we, input logic [31:0] a,
                           input logic [3:0] sel, input logic [31:0] wd);
    chk1("rom_cyc", rom_bus.cyc, tgt == T_ROM);
    chk1("rom_stb", rom_bus.stb, tgt == T_ROM);
    chk1("ram_cyc", ram_bus.cyc, tgt == T_RAM);
    chk1("ram_stb", ram_bus.stb, tgt == T_RAM);
    chk1("ram_we",  ram_bus.we,  (tgt == T_RAM) && we);
    chk1("csr_cyc", csr_bus.cyc, tgt == T_CSR);
    chk1("csr_stb", csr_bus.stb, tgt == T_CSR);
    chk1("csr_we",  csr_bus.we,  (tgt == T_CSR) && we);
    chk1("uart_cyc", uart_bus.cyc, tgt == T_UART);
    chk1("uart_stb", uart_bus.stb, tgt == T_UART);
    chk1("uart_we",  uart_bus.we,  (tgt == T_UART) && we);
    chk32("rom_adr",  rom_bus.adr,  a);
    chk32("ram_adr",  ram_bus.adr,  a);
    chk32("csr_adr",  csr_bus.adr,  a);
    chk32("uart_adr", uart_bus.adr, a);
    chk32("ram_dat",  ram_bus.dat_w,  wd);
    chk32("csr_dat",  csr_bus.dat_w,  wd);
    chk32("uart_dat", uart_bus.dat_w, wd);
    chk32("ram_sel",  {28'h0, ram_bus.sel}, {28'h0, sel});
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_rom_cyc"},  rom_bus.cyc,  1'b0);
    chk1({tag, "_ram_cyc"},  ram_bus.cyc,  1'b0);
    chk1({tag, "_ram_we"},   ram_bus.we,   1'b0);
    chk1({tag, "_csr_cyc"},  csr_bus.cyc,  1'b0);
    chk1({tag, "_uart_cyc"}, uart_bus.cyc, 1'b0);
    chk1({tag, "_ack"},      cpu_bus.ack,  1'b0);
  endtask

  // One full master transaction; routed slaves answer after two busy cycles.
  task automatic xact(input logic [31:0] a, input logic we, input logic [3:0] sel,
                      input logic [31:0] wd);
    int tgt;
    tgt = ref_target(a, we);
    @(posedge CLK_I); #1;
    cpu_bus.cyc   = 1'b1;
    cpu_bus.stb   = 1'b1;
    cpu_bus.we    = we;
    cpu_bus.sel   = sel;
    cpu_bus.adr   = a;
    cpu_bus.dat_w = wd;
    for (int k = 1; k <= 4; k++) sdat[k] = $urandom;
    drive_slaves(tgt, 1'b0);
    @(negedge CLK_I);
    chk_route(tgt, we, a, sel, wd);
    chk1("ack_early", cpu_bus.ack, 1'b0);
    if (tgt != T_ERR) begin
      chk32("rdata", cpu_bus.dat_r, sdat[tgt]);
      for (int b = 0; b < 2; b++) begin
        @(posedge CLK_I); #1;
        drive_slaves(tgt, 1'b0);
        @(negedge CLK_I);
        chk1("ack_busy", cpu_bus.ack, 1'b0);
      end
      @(posedge CLK_I); #1;
      drive_slaves(tgt, 1'b1);
      @(negedge CLK_I);
      chk1("ack_slave", cpu_bus.ack, 1'b1);
      chk32("rdata_ack", cpu_bus.dat_r, sdat[tgt]);
    end else begin
      @(posedge CLK_I); #1;
      drive_slaves(tgt, 1'b0);
      @(negedge CLK_I);
      chk1("err_ack", cpu_bus.ack, 1'b1);
      chk32("err_dat", cpu_bus.dat_r, 32'h0);
      chk_route(tgt, we, a, sel, wd);
    end
    @(posedge CLK_I); #1;
    cpu_bus.cyc = 1'b0;
    cpu_bus.stb = 1'b0;
    cpu_bus.we  = 1'b0;
    drive_slaves(T_ERR, 1'b0);
    @(negedge CLK_I);
    chk_idle("idle");
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] bnd [0:9];
    int          r;

    bnd[0] = 32'h00FF_FFFF; bnd[1] = 32'h0100_0000; bnd[2] = 32'h04FF_FFFF;
    bnd[3] = 32'h0500_0000; bnd[4] = 32'h1001_2FFF; bnd[5] = 32'h1001_301F;
    bnd[6] = 32'h1001_3020; bnd[7] = 32'h3FFF_E007; bnd[8] = 32'h3FFF_E008;
    bnd[9] = 32'h4000_0003;

    cpu_bus.cyc = 1'b0; cpu_bus.stb = 1'b0; cpu_bus.we = 1'b0;
    cpu_bus.sel = 4'h0; cpu_bus.adr = 32'h0; cpu_bus.dat_w = 32'h0;
    for (int k = 0; k <= 4; k++) sdat[k] = 32'h0;
    drive_slaves(T_ERR, 1'b0);

    // Reset state and decode during reset.
    RST_I = 1'b1;
    #12;
    chk_idle("rst");
    cpu_bus.cyc = 1'b1; cpu_bus.stb = 1'b1; cpu_bus.we = 1'b1;
    cpu_bus.adr = 32'h0100_0004;
    #1;
    chk1("rst_ram_cyc", ram_bus.cyc, 1'b1);
    chk1("rst_ram_we",  ram_bus.we,  1'b1);
    cpu_bus.cyc = 1'b0; cpu_bus.stb = 1'b0; cpu_bus.we = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;

    // Directed test-plan accesses.
    xact(32'h0100_0000, 1'b1, 4'hF, 32'h0000_0000);
    xact(32'h0000_0010, 1'b0, 4'hF, 32'h1234_5678);
    chk32("rom_adr_10", rom_bus.adr, 32'h0000_0010);
    xact(32'h1001_3004, 1'b0, 4'hF, 32'h0);
    chk32("uart_a42", {29'h0, uart_bus.adr[4:2]}, 32'd1);
    xact(32'h1001_3000, 1'b1, 4'h1, 32'h0000_0041);
    xact(32'h3FFF_E004, 1'b0, 4'hF, 32'h0);
    xact(32'h3FFF_F000, 1'b1, 4'hF, 32'hCAFE_F00D);
    xact(32'h4000_0000, 1'b1, 4'hF, 32'h1);
    xact(32'h4000_0004, 1'b0, 4'hF, 32'h0);
    xact(32'h0800_0000, 1'b0, 4'hF, 32'h0);
    xact(32'h0000_0000, 1'b1, 4'hF, 32'hDEAD_BEEF);
    xact(32'h0000_0000, 1'b0, 4'h3, 32'h0);

    // Reset while an error ACK is pending, then while it is asserted.
    @(posedge CLK_I); #1;
    cpu_bus.cyc = 1'b1; cpu_bus.stb = 1'b1; cpu_bus.we = 1'b0;
    cpu_bus.adr = 32'h0800_0000;
    drive_slaves(T_ERR, 1'b0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    #1;
    chk1("rst_pend_ack", cpu_bus.ack, 1'b0);
    @(posedge CLK_I); #1;
    chk1("rst_hold_ack", cpu_bus.ack, 1'b0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    @(posedge CLK_I); #1;
    chk1("post_rst_err_ack", cpu_bus.ack, 1'b1);
    #2;
    RST_I = 1'b1;
    #1;
    chk1("async_rst_ack", cpu_bus.ack, 1'b0);
    @(negedge CLK_I);
    chk1("rst_no_ack", cpu_bus.ack, 1'b0);
    cpu_bus.cyc = 1'b0; cpu_bus.stb = 1'b0;
    RST_I = 1'b0;
    xact(32'h0100_0040, 1'b0, 4'hF, 32'h0);

    // Randomized addresses across windows, boundaries and unmapped space.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: a = $urandom_range(32'h0000_0000, 32'h00FF_FFFF);
        1: a = $urandom_range(32'h0100_0000, 32'h04FF_FFFF);
        2: begin
          case ($urandom_range(0, 2))
            0: a = 32'h3FFF_E000;
            1: a = 32'h3FFF_F000;
            default: a = 32'h4000_0000;
          endcase
          a = a + 32'($urandom_range(0, 9));
        end
        3: a = 32'h1001_3000 + 32'($urandom_range(0, 35));
        4: a = bnd[$urandom_range(0, 9)];
        default: a = $urandom;
      endcase
      xact(a, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_memory_router

// File: doc/wb_memory_router.md
Name: wb_memory_router

Overview:
- Single-master Wishbone-style address decoder and router between the core's data/instruction bus and its slaves: ROM, RAM, the CSR memory block (MTIME/MTIMECMP/MSIP) and UART 0.
- Decodes the CPU address, forwards the cycle to exactly one slave, and returns that slave's data and ACK.
- A small clocked responder terminates accesses to unmapped or illegal targets so the core never hangs.

Parameters:
- BYTE_AMNT, 4: bytes per data word; data width DW = 8*BYTE_AMNT, SEL width = BYTE_AMNT.
- ROM_ADDR_INIT, 32'h0: ROM window start (inclusive).
- ROM_ADDR_END, 32'h00FFFFFF: ROM window end (inclusive).
- RAM_ADDR_INIT, 32'h01000000: RAM window start (inclusive).
- RAM_ADDR_END, 32'h04FFFFFF: RAM window end (inclusive).
- MTIME_ADDR, 64'h3FFFE000: base of the 8-byte MTIME register.
- MTIMECMP_ADDR, 64'h3FFFF000: base of the 8-byte MTIMECMP register.
- MSIP_ADDR, 64'h40000000: base of the 4-byte MSIP register.
- UART_0_ADDR, 32'h10013000: base of the 32-byte UART 0 window.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  asynchronous active-high reset.
- cpu_CYC_I, cpu_STB_I, cpu_WE_I  in  1 each  master cycle, strobe, write enable.
- cpu_SEL_I  in  BYTE_AMNT  byte selects.
- cpu_ADR_I  in  32  byte address.
- cpu_DAT_I  in  DW  write data.
- cpu_DAT_O  out  DW  read data to the master.
- cpu_ACK_O  out  1  acknowledge to the master.
- rom_DAT_I, rom_ACK_I  in  DW, 1  ROM read data and acknowledge.
- rom_CYC_O, rom_STB_O  out  1 each  ROM cycle and strobe.
- rom_ADR_O  out  32  ROM address.
- ram_DAT_I, ram_ACK_I  in  DW, 1  RAM read data and acknowledge.
- ram_CYC_O, ram_STB_O, ram_WE_O  out  1 each  RAM cycle, strobe, write enable.
- ram_SEL_O  out  BYTE_AMNT  RAM byte selects.
- ram_ADR_O  out  32  RAM address.
- ram_DAT_O  out  DW  RAM write data.
- csr_mem_DAT_I, csr_mem_ACK_I  in  DW, 1  CSR memory read data and acknowledge.
- csr_mem_CYC_O, csr_mem_STB_O, csr_mem_WE_O  out  1 each  CSR memory cycle, strobe, write enable.
- csr_mem_ADR_O  out  32  CSR memory address.
- csr_mem_DAT_O  out  DW  CSR memory write data.
- uart_0_DAT_I, uart_0_ACK_I  in  DW, 1  UART read data and acknowledge.
- uart_0_CYC_O, uart_0_STB_O, uart_0_WE_O  out  1 each  UART cycle, strobe, write enable.
- uart_0_ADR_O  out  32  UART address.
- uart_0_DAT_O  out  DW  UART write data.

Behaviour:
- Decode is combinational on cpu_ADR_I, zero-extended to 64 bits for the CSR compares. Windows:
  - ROM: INIT..END inclusive.
  - RAM: INIT..END inclusive.
  - CSR memory: MTIME_ADDR..+7, MTIMECMP_ADDR..+7, MSIP_ADDR..+3.
  - UART: UART_0_ADDR..+31.
- Priority if windows overlap: CSR memory > UART > RAM > ROM.
- Selected slave: CYC_O = cpu_CYC_I, STB_O = cpu_STB_I, WE_O = cpu_WE_I.
- Non-selected slaves: CYC_O = STB_O = WE_O = 0.
- ADR_O and DAT_O of every slave always mirror cpu_ADR_I / cpu_DAT_I; addresses are passed unmodified, and slaves slice their own bits (UART uses [4:2]).
- ram_SEL_O = cpu_SEL_I. ROM, CSR memory and UART have no SEL and ignore byte lanes.
- cpu_DAT_O = selected slave's DAT_I. cpu_ACK_O = selected slave's ACK_I, OR the internal error ACK.
- ROM is read-only. A write to the ROM window does not raise rom_CYC_O; it is handled by the error responder.
- Error responder (CLK_I domain) covers unmapped addresses and ROM writes:
  - err_ack register sets to 1 one cycle after cpu_CYC_I & cpu_STB_I is seen with an error target.
  - It clears the following cycle, giving a single-cycle pulse.
  - cpu_DAT_O = 0 while err_ack = 1; writes are discarded.
  - If CYC_I/STB_I drop before the pulse, no ACK is issued.
- Latency: routed paths are purely combinational (zero added cycles); slave wait states pass through unchanged. Error path latency is 1 cycle.
- Reset (RST_I = 1, asynchronous): err_ack = 0 immediately.
  - All slave CYC/STB/WE outputs still follow decode, so they are 0 whenever cpu_CYC_I = 0.
  - Reset mid-transaction aborts any pending error ACK.
- Idle (cpu_CYC_I = 0): all slave CYC/STB/WE = 0 and cpu_ACK_O = 0. cpu_DAT_O follows the currently decoded slave; its value is don't-care.

Test Plan:
- Write 0 to 0x01000000 with SEL=4'hF, WE=1 -> ram_CYC_O/STB_O/WE_O=1, ram_SEL_O=4'hF, ram_DAT_O=0, ROM/UART/CSR strobes 0, cpu_ACK_O follows ram_ACK_I (2-cycle-busy slave -> ACK after 2 cycles).
- Read 0x00000010 -> rom_CYC_O/STB_O=1, rom_ADR_O=0x10, cpu_DAT_O=rom_DAT_I, cpu_ACK_O=rom_ACK_I.
- Read 0x10013004 (UART status) -> uart_0_CYC_O=1, uart_0_ADR_O[4:2]=1, cpu_DAT_O=uart_0_DAT_I; write 0x10013000 with data 0x41 -> uart_0_WE_O=1, uart_0_DAT_O=0x41.
- Access 0x3FFFE004, 0x3FFFF000 and 0x40000000 -> csr_mem_CYC_O=1 for each; 0x40000004 -> not CSR, error ACK.
- Read 0x08000000 (unmapped) -> no slave strobe, cpu_ACK_O=1 exactly one cycle later, cpu_DAT_O=0; write to 0x00000000 -> rom_CYC_O=0, single-cycle error ACK.
- Assert RST_I while an error ACK is pending -> err_ack = 0 immediately, no ACK emitted; normal decode resumes after release.
